pio_dma_32_rx_engine: RTL and testbench

32-bit TRN local-link receive engine for the PCIe endpoint: parses incoming TLPs, decodes 3DW Memory Read and Memory Write requests, and drives the register-file write port and the completion request towards the 32-bit TX engine. Memory Reads latch the requester fields and hold `req_compl_o` until the TX engine returns `compl_done_i`. Memory Writes stream their payload as one register write per DW. All other TLP types are consumed and discarded.

---
 rtl/pio_dma_32_rx_engine_if.sv | 25 ++
 rtl/pio_dma_32_rx_engine.sv | 163 ++++++++++++++++
 tb/tb_pio_dma_32_rx_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_dma_32_rx_engine_if.sv
// pio_dma_32_rx_engine_if: TRN local-link receive bus between the PCIe core (master) and the RX engine (slave)
//   trn_rd         : receive data beat
//   trn_rsof_n     : start of frame, active-low
//   trn_reof_n     : end of frame, active-low
//   trn_rsrc_rdy_n : source ready, active-low
//   trn_rsrc_dsc_n : source discontinue, active-low
//   trn_rdst_rdy_n : destination ready, active-low (driven by the slave)
//   trn_rbar_hit_n : BAR hit vector, active-low
interface pio_dma_32_rx_engine_if;
   logic [31:0] trn_rd;
   logic        trn_rsof_n;
   logic        trn_reof_n;
   logic        trn_rsrc_rdy_n;
   logic        trn_rsrc_dsc_n;
   logic        trn_rdst_rdy_n;
   logic [6:0]  trn_rbar_hit_n;
   modport master (
      output trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
      input  trn_rdst_rdy_n
   );
   modport slave (
      input  trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
      output trn_rdst_rdy_n
   );
endinterface

// File: rtl/pio_dma_32_rx_engine.sv
// pio_dma_32_rx_engine: 32-bit TRN receive engine decoding MRd/MWr TLPs into completion requests and register writes
//   clk, rst              : user clock, synchronous active-high reset
//   rx                    : TRN receive bus (slave modport)
//   req_compl_o           : completion pending towards the TX engine
//   req_compl_with_data_o : pending completion carries data
//   compl_done_i          : completion sent, single-cycle pulse
//   req_*_o               : latched request header fields, req_addr_o is the byte address [12:0]
//   wr_addr_o/be/data/en  : register write port, wr_busy_i backpressures it
//   Optional: define PIO_RX_MEM64_EN to also decode 4DW MRd64/MWr64 requests
module pio_dma_32_rx_engine #(
   parameter int WR_ADDR_W = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   pio_dma_32_rx_engine_if.slave rx,
   output logic                 req_compl_o,
   output logic                 req_compl_with_data_o,
   input  logic                 compl_done_i,
   output logic [2:0]           req_tc_o,
   output logic                 req_td_o,
   output logic                 req_ep_o,
   output logic [1:0]           req_attr_o,
   output logic [9:0]           req_len_o,
   output logic [15:0]          req_rid_o,
   output logic [7:0]           req_tag_o,
   output logic [7:0]           req_be_o,
   output logic [12:0]          req_addr_o,
   output logic [WR_ADDR_W-1:0] wr_addr_o,
   output logic [3:0]           wr_be_o,
   output logic [31:0]          wr_data_o,
   output logic                 wr_en_o,
   input  logic                 wr_busy_i
);
   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] RD_DW1     = 4'd1;
   localparam logic [3:0] RD_DW2     = 4'd2;
   localparam logic [3:0] WR_DW1     = 4'd3;
   localparam logic [3:0] WR_DW2     = 4'd4;
   localparam logic [3:0] WR_DATA    = 4'd5;
   localparam logic [3:0] WAIT_COMPL = 4'd6;
   localparam logic [3:0] DISCARD    = 4'd7;

   logic [3:0]  state, nxt, hop_st;
   logic [10:0] cnt;
   logic [6:0]  ft;
   logic        rdy_q, first, acc, go, sof, eof, bar_hit;
   logic        mrd, mwr, rd_adr, wr_adr, hop, unused_bar;

   assign ft      = rx.trn_rd[30:24];
   assign sof     = !rx.trn_rsof_n;
   assign eof     = !rx.trn_reof_n;
   assign bar_hit = !rx.trn_rbar_hit_n[0];
   assign unused_bar = &{1'b0, rx.trn_rbar_hit_n[6:1]};
   // Registered part throttles from the cycle WAIT_COMPL is entered; write backpressure acts immediately
   assign rx.trn_rdst_rdy_n = rdy_q | (state == WR_DATA && wr_busy_i);
   assign acc = !rx.trn_rsrc_rdy_n && !rx.trn_rdst_rdy_n;
   // A discontinued beat is never processed
   assign go  = acc && rx.trn_rsrc_dsc_n;

`ifdef PIO_RX_MEM64_EN
   localparam logic [3:0] RD_DW3 = 4'd8;
   localparam logic [3:0] WR_DW3 = 4'd9;
   logic m64;
   always_ff @(posedge clk)
      if (rst) m64 <= 1'b0;
      else if (state == IDLE && go) m64 <= rx.trn_rd[29];
   assign mrd    = ft == 7'h00 || ft == 7'h20;
   assign mwr    = ft == 7'h40 || ft == 7'h60;
   // 4DW headers skip the upper-address DW2 and take the address from DW3
   assign hop    = m64 && (state == RD_DW2 || state == WR_DW2);
   assign hop_st = state == RD_DW2 ? RD_DW3 : WR_DW3;
   assign rd_adr = (state == RD_DW2 && !m64) || state == RD_DW3;
   assign wr_adr = (state == WR_DW2 && !m64) || state == WR_DW3;
`else
   assign mrd    = ft == 7'h00;
   assign mwr    = ft == 7'h40;
   assign hop    = 1'b0;
   assign hop_st = IDLE;
   assign rd_adr = state == RD_DW2;
   assign wr_adr = state == WR_DW2;
`endif

   always_comb begin
      nxt = state;
      if (!rx.trn_rsrc_dsc_n) nxt = IDLE;
      else if (state == WAIT_COMPL) nxt = compl_done_i ? IDLE : WAIT_COMPL;
      else if (go) begin
         if (state == IDLE)
            nxt = (sof && bar_hit && mrd) ? RD_DW1 : (sof && bar_hit && mwr) ? WR_DW1 : eof ? IDLE : DISCARD;
         else if (state == WR_DATA) nxt = eof ? IDLE : (cnt == 11'd1) ? DISCARD : WR_DATA;
         else if (rd_adr) nxt = WAIT_COMPL;
         // EOF also terminates truncated headers and drained TLPs
         else if (eof) nxt = IDLE;
         else if (wr_adr) nxt = WR_DATA;
         else if (hop) nxt = hop_st;
         else if (state == RD_DW1) nxt = RD_DW2;
         else if (state == WR_DW1) nxt = WR_DW2;
         else if (state != DISCARD) nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         rdy_q                 <= 1'b1;
         first                 <= 1'b0;
         cnt                   <= '0;
         req_compl_o           <= 1'b0;
         req_compl_with_data_o <= 1'b0;
         req_tc_o              <= '0;
         req_td_o              <= 1'b0;
         req_ep_o              <= 1'b0;
         req_attr_o            <= '0;
         req_len_o             <= '0;
         req_rid_o             <= '0;
         req_tag_o             <= '0;
         req_be_o              <= '0;
         req_addr_o            <= '0;
         wr_addr_o             <= '0;
         wr_be_o               <= '0;
         wr_data_o             <= '0;
         wr_en_o               <= 1'b0;
      end else begin
         state   <= nxt;
         rdy_q   <= nxt == WAIT_COMPL;
         wr_en_o <= go && state == WR_DATA;
         if (wr_en_o) wr_addr_o <= wr_addr_o + 1'b1;
         if (state == IDLE && nxt == RD_DW1) begin
            req_tc_o   <= rx.trn_rd[22:20];
            req_td_o   <= rx.trn_rd[15];
            req_ep_o   <= rx.trn_rd[14];
            req_attr_o <= rx.trn_rd[13:12];
            req_len_o  <= rx.trn_rd[9:0];
         end
         // len=0 encodes 1024 DW
         if (state == IDLE && nxt == WR_DW1) cnt <= {rx.trn_rd[9:0] == 10'd0, rx.trn_rd[9:0]};
         if (go && (state == RD_DW1 || state == WR_DW1)) begin
            req_rid_o <= rx.trn_rd[31:16];
            req_tag_o <= rx.trn_rd[15:8];
            req_be_o  <= rx.trn_rd[7:0];
         end
         if (go && (rd_adr || wr_adr)) req_addr_o <= {rx.trn_rd[12:2], 2'b00};
         if (go && wr_adr) begin
            wr_addr_o <= rx.trn_rd[WR_ADDR_W+1:2];
            first     <= 1'b1;
         end
         if (go && rd_adr) begin
            req_compl_o           <= 1'b1;
            req_compl_with_data_o <= 1'b1;
         end
         if (go && state == WR_DATA) begin
            wr_data_o <= rx.trn_rd;
            wr_be_o   <= first ? req_be_o[3:0] : (cnt == 11'd1) ? req_be_o[7:4] : 4'hF;
            cnt       <= cnt - 1'b1;
            first     <= 1'b0;
         end
         if (!rx.trn_rsrc_dsc_n || (state == WAIT_COMPL && compl_done_i)) begin
            req_compl_o           <= 1'b0;
            req_compl_with_data_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pio_dma_32_rx_engine.sv
// tb_pio_dma_32_rx_engine: directed self-checking bench for the 32-bit TRN RX engine
module tb_pio_dma_32_rx_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_compl_o, req_compl_with_data_o, compl_done_i, req_td_o, req_ep_o, wr_en_o, wr_busy_i;
   logic [2:0]  req_tc_o;
   logic [1:0]  req_attr_o;
   logic [9:0]  req_len_o;
   logic [15:0] req_rid_o;
   logic [7:0]  req_tag_o, req_be_o;
   logic [12:0] req_addr_o;
   logic [10:0] wr_addr_o;
   logic [3:0]  wr_be_o;
   logic [31:0] wr_data_o;
   logic [10:0] q_addr[$];
   logic [3:0]  q_be[$];
   logic [31:0] q_data[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   pio_dma_32_rx_engine_if rx();

   pio_dma_32_rx_engine dut (
      .clk                   (clk),
      .rst                   (rst),
      .rx                    (rx),
      .req_compl_o           (req_compl_o),
      .req_compl_with_data_o (req_compl_with_data_o),
      .compl_done_i          (compl_done_i),
      .req_tc_o              (req_tc_o),
      .req_td_o              (req_td_o),
      .req_ep_o              (req_ep_o),
      .req_attr_o            (req_attr_o),
      .req_len_o             (req_len_o),
      .req_rid_o             (req_rid_o),
      .req_tag_o             (req_tag_o),
      .req_be_o              (req_be_o),
      .req_addr_o            (req_addr_o),
      .wr_addr_o             (wr_addr_o),
      .wr_be_o               (wr_be_o),
      .wr_data_o             (wr_data_o),
      .wr_en_o               (wr_en_o),
      .wr_busy_i             (wr_busy_i)
   );

   always @(negedge clk)
      if (wr_en_o === 1'b1) begin
         q_addr.push_back(wr_addr_o);
         q_be.push_back(wr_be_o);
         q_data.push_back(wr_data_o);
      end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_wr(input int i, input logic [10:0] a, input logic [3:0] b, input logic [31:0] d);
      chk($sformatf("wr%0d_addr", i), q_addr[i], a);
      chk($sformatf("wr%0d_be", i), q_be[i], b);
      chk($sformatf("wr%0d_data", i), q_data[i], d);
   endtask

   task automatic clr();
      q_addr.delete();
      q_be.delete();
      q_data.delete();
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted
   task automatic beat(input logic [31:0] d, input logic s, input logic e);
      int n;
      n = 0;
      rx.trn_rd = d;
      rx.trn_rsof_n = !s;
      rx.trn_reof_n = !e;
      rx.trn_rsrc_rdy_n = 1'b0;
      #1;
      while (rx.trn_rdst_rdy_n !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("beat_timeout", n, 0);
      @(negedge clk);
      rx.trn_rsrc_rdy_n = 1'b1;
      rx.trn_rsof_n = 1'b1;
      rx.trn_reof_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rx.trn_rd = '0;
      rx.trn_rsof_n = 1'b1;
      rx.trn_reof_n = 1'b1;
      rx.trn_rsrc_rdy_n = 1'b1;
      rx.trn_rsrc_dsc_n = 1'b1;
      rx.trn_rbar_hit_n = 7'h7E;
      wr_busy_i = 1'b0;
      compl_done_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy_n", rx.trn_rdst_rdy_n, 1);
      chk("rst_compl", req_compl_o, 0);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_req_addr", req_addr_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", rx.trn_rdst_rdy_n, 0);

      // MRd32: tc=2, attr=1, len=1
      beat(32'h0020_1001, 1, 0);
      beat(32'h0100_050F, 0, 0);
      chk("mrd_compl_early", req_compl_o, 0);
      beat(32'h0000_0104, 0, 1);
      chk("mrd_compl", req_compl_o, 1);
      chk("mrd_with_data", req_compl_with_data_o, 1);
      chk("mrd_addr", req_addr_o, 13'h104);
      chk("mrd_tag", req_tag_o, 8'h05);
      chk("mrd_rid", req_rid_o, 16'h0100);
      chk("mrd_be", req_be_o, 8'h0F);
      chk("mrd_len", req_len_o, 10'd1);
      chk("mrd_tc", req_tc_o, 3'd2);
      chk("mrd_attr", req_attr_o, 2'd1);
      chk("mrd_rdy_n", rx.trn_rdst_rdy_n, 1);
      repeat (2) @(negedge clk);
      chk("mrd_hold_compl", req_compl_o, 1);
      chk("mrd_hold_rdy_n", rx.trn_rdst_rdy_n, 1);
      compl_done_i = 1'b1;
      @(negedge clk);
      compl_done_i = 1'b0;
      chk("mrd_done_compl", req_compl_o, 0);
      chk("mrd_done_rdy_n", rx.trn_rdst_rdy_n, 0);
      chk("mrd_no_write", q_addr.size(), 0);

      // MWr32 len=3 at 0x10, first BE 3, last BE C
      clr();
      beat(32'h4000_0003, 1, 0);
      beat(32'h0100_06C3, 0, 0);
      beat(32'h0000_0010, 0, 0);
      beat(32'hA1A1_A1A1, 0, 0);
      beat(32'hA2A2_A2A2, 0, 0);
      beat(32'hA3A3_A3A3, 0, 1);
      @(negedge clk);
      chk("mwr_count", q_addr.size(), 3);
      chk_wr(0, 11'h004, 4'h3, 32'hA1A1_A1A1);
      chk_wr(1, 11'h005, 4'hF, 32'hA2A2_A2A2);
      chk_wr(2, 11'h006, 4'hC, 32'hA3A3_A3A3);

      // MWr32 len=2 with write-port backpressure mid-payload
      clr();
      beat(32'h4000_0002, 1, 0);
      beat(32'h0100_07FF, 0, 0);
      beat(32'h0000_0040, 0, 0);
      beat(32'hB1B1_B1B1, 0, 0);
      wr_busy_i = 1'b1;
      rx.trn_rd = 32'hB2B2_B2B2;
      rx.trn_reof_n = 1'b0;
      rx.trn_rsrc_rdy_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("busy_rdy_n%0d", i), rx.trn_rdst_rdy_n, 1);
         @(negedge clk);
      end
      wr_busy_i = 1'b0;
      beat(32'hB2B2_B2B2, 0, 1);
      @(negedge clk);
      chk("busy_count", q_addr.size(), 2);
      chk_wr(0, 11'h010, 4'hF, 32'hB1B1_B1B1);
      chk_wr(1, 11'h011, 4'hF, 32'hB2B2_B2B2);

      // CplD is discarded
      clr();
      beat(32'h4A00_0001, 1, 0);
      beat(32'h1111_1111, 0, 0);
      beat(32'h2222_2222, 0, 0);
      beat(32'h3333_3333, 0, 1);
      @(negedge clk);
      chk("cpl_wr_count", q_addr.size(), 0);
      chk("cpl_compl", req_compl_o, 0);
      chk("cpl_rdy_n", rx.trn_rdst_rdy_n, 0);

      // MWr32 missing BAR0 is discarded
      rx.trn_rbar_hit_n = 7'h7F;
      beat(32'h4000_0001, 1, 0);
      beat(32'h0100_0B0F, 0, 0);
      beat(32'h0000_0010, 0, 0);
      beat(32'hDDDD_DDDD, 0, 1);
      rx.trn_rbar_hit_n = 7'h7E;
      @(negedge clk);
      chk("bar_wr_count", q_addr.size(), 0);

      // Discontinue on payload beat 2 of a len=4 MWr
      beat(32'h4000_0004, 1, 0);
      beat(32'h0100_08FF, 0, 0);
      beat(32'h0000_0080, 0, 0);
      beat(32'hC1C1_C1C1, 0, 0);
      rx.trn_rsrc_dsc_n = 1'b0;
      beat(32'hC2C2_C2C2, 0, 0);
      rx.trn_rsrc_dsc_n = 1'b1;
      @(negedge clk);
      chk("dsc_count", q_addr.size(), 1);
      chk_wr(0, 11'h020, 4'hF, 32'hC1C1_C1C1);
      beat(32'h0000_0001, 1, 0);
      beat(32'h0200_090F, 0, 0);
      beat(32'h0000_0208, 0, 1);
      chk("dsc_mrd_compl", req_compl_o, 1);
      chk("dsc_mrd_addr", req_addr_o, 13'h208);
      chk("dsc_mrd_tag", req_tag_o, 8'h09);
      chk("dsc_mrd_rid", req_rid_o, 16'h0200);

      // Reset while a completion is outstanding
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_compl", req_compl_o, 0);
      chk("rstw_with_data", req_compl_with_data_o, 0);
      chk("rstw_rdy_n", rx.trn_rdst_rdy_n, 1);
      chk("rstw_wr_en", wr_en_o, 0);
      chk("rstw_req_addr", req_addr_o, 0);
      chk("rstw_tag", req_tag_o, 0);
      chk("rstw_rid", req_rid_o, 0);
      chk("rstw_len", req_len_o, 0);
      chk("rstw_wr_addr", wr_addr_o, 0);
      chk("rstw_wr_be", wr_be_o, 0);
      chk("rstw_wr_data", wr_data_o, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstw_rdy_after", rx.trn_rdst_rdy_n, 0);

      // len=2 write wrapping the DW address, first BE A, last BE 5
      clr();
      beat(32'h4000_0002, 1, 0);
      beat(32'h0100_0C5A, 0, 0);
      beat(32'h0000_1FFC, 0, 0);
      beat(32'hE1E1_E1E1, 0, 0);
      beat(32'hE2E2_E2E2, 0, 1);
      @(negedge clk);
      chk("wrap_count", q_addr.size(), 2);
      chk_wr(0, 11'h7FF, 4'hA, 32'hE1E1_E1E1);
      chk_wr(1, 11'h000, 4'h5, 32'hE2E2_E2E2);

      // 1-DW write takes the first BE
      clr();
      beat(32'h4000_0001, 1, 0);
      beat(32'h0100_0D5A, 0, 0);
      beat(32'h0000_0300, 0, 0);
      beat(32'hF1F1_F1F1, 0, 1);
      @(negedge clk);
      chk("one_count", q_addr.size(), 1);
      chk_wr(0, 11'h0C0, 4'hA, 32'hF1F1_F1F1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
